// File: rtl/iob_rom_sp_tiled_if.sv
// Load/read bus of the tiled boot ROM: boot-loader stream plus CPU read port.
interface iob_rom_sp_tiled_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              reload;
  logic              init_done;
  logic              r_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  modport master (
    output ld_valid, ld_data, ld_last, reload, r_en, addr,
    input  ld_ready, init_done, r_data, r_valid
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, reload, r_en, addr,
    output ld_ready, init_done, r_data, r_valid
  );
endinterface

// File: rtl/iob_rom_sp_tiled.sv
// Boot-loaded ROM tiled from 32x1024 single-port SRAM tiles: NC columns by NB banks.
// The image is streamed in after reset; reads are served only once loading completes.
module iob_rom_sp_tiled #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 11,
  parameter bit          OUT_REG = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  iob_rom_sp_tiled_if.slave bus
);
  localparam int unsigned NC     = DATA_W / 32;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned NB     = 1 << (ADDR_W - ROW_W);
  localparam int unsigned BANK_W = (ADDR_W > ROW_W) ? (ADDR_W - ROW_W) : 1;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [ADDR_W-1:0]            ptr;
  logic                         ld_ready_q;
  logic                         init_done_q;
  logic                         ld_acc;
  logic                         rd_acc;

  // Tile pins (port 0 only; port 1 of every tile is tied off: clk1=0, csb1=1)
  logic [NB-1:0]                csb0;
  logic                         web0;
  logic [3:0]                   wmask0;
  logic [ROW_W-1:0]             addr0;
  logic [DATA_W-1:0]            din0;
  logic [NB-1:0][DATA_W-1:0]    dout0;

  logic [BANK_W-1:0]            sel_bank;
  logic [BANK_W-1:0]            bank_q;
  logic                         rd_vld;
  logic                         cap;
  logic                         vld_q;
  logic [DATA_W-1:0]            hold_q;
  logic [DATA_W-1:0]            mux_data;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return (ADDR_W > ROW_W) ? BANK_W'(a >> ROW_W) : '0;
  endfunction

  // reload always wins over a load word or a read in the same cycle
  assign ld_acc = (state == S_LOAD) && bus.ld_valid && ld_ready_q && !bus.reload;
  assign rd_acc = (state == S_RUN) && bus.r_en && !bus.reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (ld_acc && (bus.ld_last || ptr == PTR_MAX)) state_nxt = S_RUN;
      S_RUN:   if (bus.reload) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Tile control: only the addressed bank is enabled, all others stay deselected
  always_comb begin
    csb0     = '1;
    web0     = 1'b1;
    wmask0   = 4'h0;
    addr0    = '0;
    din0     = '0;
    sel_bank = '0;
    case (state)
      S_LOAD: if (ld_acc) begin
        sel_bank       = bank_of(ptr);
        csb0[sel_bank] = 1'b0;
        web0           = 1'b0;
        wmask0         = 4'hF;
        addr0          = ROW_W'(ptr);
        din0           = bus.ld_data;
      end
      S_RUN: if (rd_acc) begin
        sel_bank       = bank_of(bus.addr);
        csb0[sel_bank] = 1'b0;
        addr0          = ROW_W'(bus.addr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      ld_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      ld_ready_q  <= (state_nxt == S_LOAD);
      init_done_q <= (state_nxt == S_RUN);
      if (bus.reload)  ptr <= '0;
      else if (ld_acc) ptr <= ptr + 1'b1;
    end
  end

  // Behavioural stand-in for the 32x1024 tile, same port-0 pin semantics
  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar c = 0; c < NC; c++) begin : g_col
      logic [31:0] mem [1024];
      logic [31:0] q;
      logic [31:0] wr_word;

      always_comb begin
        wr_word = mem[addr0];
        for (int k = 0; k < 4; k++)
          if (wmask0[k]) wr_word[8*k +: 8] = din0[32*c + 8*k +: 8];
      end

      always_ff @(posedge clk) begin
        if (!csb0[b]) begin
          if (!web0) mem[addr0] <= wr_word;
          else       q          <= mem[addr0];
        end
      end

      assign dout0[b][32*c +: 32] = q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      bank_q <= '0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) bank_q <= sel_bank;
    end
  end

  assign mux_data = dout0[bank_q];

  // With the extra stage, a reload drops the read still sitting in the first stage
  assign cap = OUT_REG ? (rd_vld && !bus.reload) : rd_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      vld_q <= cap;
      if (cap) hold_q <= mux_data;
    end
  end

  assign bus.r_valid   = OUT_REG ? vld_q : rd_vld;
  assign bus.r_data    = (OUT_REG || !rd_vld) ? hold_q : mux_data;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.init_done = init_done_q;
endmodule

// File: doc/iob_rom_sp_tiled.md
Name: iob_rom_sp_tiled

Overview:
- Parametrised single-port ROM built from tiled sky130_sram_4kbyte_1rw1r_32x1024_8 macros (32b x 1024 words each).
- Tiles macros in width (columns) and depth (banks).
- The macros cannot be initialised from a hex file, so the block has a boot-load port that streams the ROM image in after reset. The block serves reads only once loading is complete.
- Sits between the boot controller (image source) and the CPU instruction/data read path.

Parameters:
- DATA_W, 32, read/load word width; multiple of 32, range 32..128. Columns NC = DATA_W/32.
- ADDR_W, 11, word address width; range 10..13. Banks NB = 2^(ADDR_W-10).
- OUT_REG, 0, 1 = extra output register stage (read latency 2 instead of 1).

Ports:
- clk  input  1  clock; all macros are clocked on clk0 from it.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  load word present.
- ld_ready  output  1  block accepts load word.
- ld_data  input  DATA_W  load word; written at current load pointer.
- ld_last  input  1  marks final load word.
- reload  input  1  single-cycle pulse; restarts loading from address 0.
- init_done  output  1  high when the image is loaded and reads are served.
- r_en  input  1  read request.
- addr  input  ADDR_W  read word address.
- r_data  output  DATA_W  read data.
- r_valid  output  1  r_data valid this cycle (single-cycle pulse per accepted read).

Behaviour:
- Reset values: FSM=LOAD, load pointer=0, ld_ready=0 for the first cycle after reset release then 1, init_done=0, r_valid=0, r_data=0. Macro contents are undefined after reset.
- FSM states:
  - LOAD: ld_ready=1. On ld_valid&ld_ready, write ld_data to macro bank = ptr[ADDR_W-1:10], row = ptr[9:0], all NC columns: csb0=0, web0=0, wmask0=4'hF. Pointer then increments.
  - LOAD -> RUN: on an accepted word with ld_last=1, or an accepted word at ptr = 2^ADDR_W-1 (full). No wrap-around writes.
  - RUN: init_done=1, ld_ready=0. Load-port inputs are ignored.
  - RUN -> LOAD: on reload=1. Pointer cleared to 0, init_done drops the next cycle, any in-flight r_valid is suppressed.
- Read path (RUN only):
  - r_en in cycle T drives csb0=0/web0=1 on the selected bank only. Unselected banks get csb0=1 (power).
  - Bank index is registered; the output mux selects with the registered index.
  - OUT_REG=0: r_data/r_valid in T+1. OUT_REG=1: in T+2.
  - r_data holds its last value when r_valid=0.
  - Back-to-back reads are accepted every cycle (fully pipelined, no backpressure).
- r_en in LOAD: ignored, no r_valid, no macro access.
- reload and r_en in the same cycle: reload wins, the read is dropped.
- reload in LOAD: restarts pointer at 0.
- Port 1 of every macro is unused: clk1=0, csb1=1.
- rst_n asserted mid-load or mid-read: outputs return to reset values immediately (asynchronous). No r_valid for the interrupted read; the image must be reloaded.

Test Plan:
- DATA_W=32, ADDR_W=11, reset, stream 2048 words (word i = 32'hA500_0000+i), no ld_last -> init_done rises the cycle after word 2047. Reads at 0, 1023, 1024, 2047 return A5000000, A50003FF, A5000400, A50007FF at T+1 with r_valid.
- Load 5 words with ld_last on the 5th -> ld_ready=0 and init_done=1 next cycle. A sixth ld_valid is ignored. Read addr 4 returns word 4.
- OUT_REG=1, DATA_W=64: back-to-back reads at addresses 3, 1500, 7 -> three consecutive r_valid pulses starting T+2, data in order, 64-bit values intact across both columns.
- r_en during LOAD -> no r_valid, no macro read (csb0=1 on all banks). Reload pulse coincident with r_en in RUN -> no r_valid, init_done=0 next cycle, reload of new image, old addresses return new data.
- rst_n asserted mid-load (after 100 words) -> init_done=0, r_valid=0, pointer 0. Full reload then reads correct.
- Bank isolation: a read at addr 1024 enables only the bank-1 csb0; all others stay high (checked by assertion).
